// File: rtl/pe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pe_pkg
// Description : Shared types and constants for the pe_vec_cell MAC cell.
// Revision    : 1.0 - initial release
// ============================================================================
package pe_pkg;

    localparam int c_MAC_LATENCY_MIN = 1;
    localparam int c_MAC_LATENCY_MAX = 4;
    localparam int c_CNT_W           = $clog2(c_MAC_LATENCY_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } pe_state_t;

endpackage : pe_pkg
`default_nettype wire

// File: rtl/pe_mac_lane.sv
`default_nettype none
// ============================================================================
// Module      : pe_mac_lane
// Description : One signed MAC lane: multiplier, product pipeline and
//               accumulator; saturating adds when PE_SATURATE_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module pe_mac_lane
    import pe_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int ACC_WIDTH   = 40,
    parameter int MAC_LATENCY = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         en_i,
    input  logic                         first_i,
    input  logic                         clr_i,
    input  logic signed [DATA_WIDTH-1:0] north_i,
    input  logic signed [DATA_WIDTH-1:0] west_i,
    output logic signed [ACC_WIDTH-1:0]  acc_o,
    output logic                         ovf_o
);

    logic signed [2*DATA_WIDTH-1:0] w_mul;
    logic signed [ACC_WIDTH-1:0]    w_prod;
    logic signed [ACC_WIDTH-1:0]    w_next;
    logic                           w_ovf;

    logic signed [ACC_WIDTH-1:0]    r_prod  [MAC_LATENCY];
    logic [MAC_LATENCY-1:0]         r_vld;
    logic [MAC_LATENCY-1:0]         r_first;
    logic signed [ACC_WIDTH-1:0]    r_acc;

    assign w_mul  = north_i * west_i;
    assign w_prod = ACC_WIDTH'(w_mul);

`ifdef PE_SATURATE_EN
    localparam logic signed [ACC_WIDTH-1:0] c_ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] c_ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    logic signed [ACC_WIDTH:0] w_sum;

    // One extra bit exposes signed overflow as a mismatch of the top two bits.
    assign w_sum  = {r_acc[ACC_WIDTH-1], r_acc}
                  + {r_prod[MAC_LATENCY-1][ACC_WIDTH-1], r_prod[MAC_LATENCY-1]};
    assign w_ovf  = w_sum[ACC_WIDTH] ^ w_sum[ACC_WIDTH-1];
    assign w_next = w_ovf ? (w_sum[ACC_WIDTH] ? c_ACC_MIN : c_ACC_MAX)
                          : w_sum[ACC_WIDTH-1:0];
`else
    assign w_ovf  = 1'b0;
    assign w_next = r_acc + r_prod[MAC_LATENCY-1];
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < MAC_LATENCY; i++) begin
                r_prod[i] <= '0;
            end
            r_vld   <= '0;
            r_first <= '0;
        end else begin
            r_prod[0]  <= w_prod;
            r_vld[0]   <= en_i;
            r_first[0] <= first_i;
            for (int i = 1; i < MAC_LATENCY; i++) begin
                r_prod[i]  <= r_prod[i-1];
                r_vld[i]   <= r_vld[i-1];
                r_first[i] <= r_first[i-1];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            r_acc <= '0;
        end else if (r_vld[MAC_LATENCY-1]) begin
            r_acc <= r_first[MAC_LATENCY-1] ? r_prod[MAC_LATENCY-1] : w_next;
        end
    end

    assign acc_o = r_acc;
    assign ovf_o = r_vld[MAC_LATENCY-1] & ~r_first[MAC_LATENCY-1] & w_ovf;

endmodule : pe_mac_lane
`default_nettype wire

// File: rtl/pe_vec_cell.sv
`default_nettype none
// ============================================================================
// Module      : pe_vec_cell
// Description : Systolic vector MAC cell with LANES parallel lanes, 1-cycle
//               passthrough and drain-on-request results. Optional
//               saturation via the PE_SATURATE_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
module pe_vec_cell
    import pe_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int ACC_WIDTH   = 40,
    parameter int LANES       = 4,
    parameter int MAC_LATENCY = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [LANES*DATA_WIDTH-1:0] north_i,
    input  logic [DATA_WIDTH-1:0]       west_i,
    input  logic                        valid_i,
    input  logic                        first_i,
    input  logic                        last_i,
    input  logic                        drain_i,
    output logic [LANES*DATA_WIDTH-1:0] south_o,
    output logic [DATA_WIDTH-1:0]       east_o,
    output logic                        valid_o,
    output logic [LANES*ACC_WIDTH-1:0]  acc_o,
    output logic                        acc_valid_o,
    output logic                        done_o,
    output logic                        overflow_o
);

    pe_state_t                   r_state;
    logic [c_CNT_W-1:0]          r_cnt;
    logic [LANES*ACC_WIDTH-1:0]  w_acc;
    logic [LANES-1:0]            w_ovf;
    logic                        w_accept;
    logic                        w_first;
    logic                        w_clr;

    // The MAC only takes elements while an accumulation is open; IDLE forces a load.
    assign w_accept = valid_i & ((r_state == ST_IDLE) | (r_state == ST_ACCUM));
    assign w_first  = first_i | (r_state == ST_IDLE);
    assign w_clr    = (r_state == ST_DONE) & drain_i;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        pe_mac_lane #(
            .DATA_WIDTH  (DATA_WIDTH),
            .ACC_WIDTH   (ACC_WIDTH),
            .MAC_LATENCY (MAC_LATENCY)
        ) u_lane (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .en_i    (w_accept),
            .first_i (w_first),
            .clr_i   (w_clr),
            .north_i (north_i[k*DATA_WIDTH +: DATA_WIDTH]),
            .west_i  (west_i),
            .acc_o   (w_acc[k*ACC_WIDTH +: ACC_WIDTH]),
            .ovf_o   (w_ovf[k])
        );
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            south_o     <= '0;
            east_o      <= '0;
            valid_o     <= 1'b0;
            acc_o       <= '0;
            acc_valid_o <= 1'b0;
            done_o      <= 1'b0;
            overflow_o  <= 1'b0;
        end else begin
            valid_o     <= valid_i;
            acc_valid_o <= 1'b0;
            if (valid_i) begin
                south_o <= north_i;
                east_o  <= west_i;
            end
            if (|w_ovf) begin
                overflow_o <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (valid_i) begin
                        r_state <= last_i ? ST_FLUSH : ST_ACCUM;
                        r_cnt   <= '0;
                    end
                end
                ST_ACCUM: begin
                    if (valid_i && last_i) begin
                        r_state <= ST_FLUSH;
                        r_cnt   <= '0;
                    end
                end
                ST_FLUSH: begin
                    if (r_cnt == c_CNT_W'(MAC_LATENCY)) begin
                        r_state <= ST_DONE;
                        done_o  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (drain_i) begin
                        acc_o       <= w_acc;
                        acc_valid_o <= 1'b1;
                        done_o      <= 1'b0;
                        overflow_o  <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule : pe_vec_cell
`default_nettype wire

// File: tb/tb_pe_vec_cell.sv
`default_nettype none
// ============================================================================
// Module      : tb_pe_vec_cell
// Description : Directed self-checking bench for pe_vec_cell (4 lanes,
//               16-bit data, 32-bit accumulators, MAC latency 2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pe_vec_cell;

    localparam int DW = 16;
    localparam int AW = 32;
    localparam int LN = 4;
    localparam int ML = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [LN*DW-1:0] north;
    logic [DW-1:0]    west;
    logic             valid, first, last, drain;
    logic [LN*DW-1:0] south_o;
    logic [DW-1:0]    east_o;
    logic             valid_o;
    logic [LN*AW-1:0] acc_o;
    logic             acc_valid_o, done_o, overflow_o;

    int checks   = 0;
    int failures = 0;

    pe_vec_cell #(
        .DATA_WIDTH  (DW),
        .ACC_WIDTH   (AW),
        .LANES       (LN),
        .MAC_LATENCY (ML)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .north_i     (north),
        .west_i      (west),
        .valid_i     (valid),
        .first_i     (first),
        .last_i      (last),
        .drain_i     (drain),
        .south_o     (south_o),
        .east_o      (east_o),
        .valid_o     (valid_o),
        .acc_o       (acc_o),
        .acc_valid_o (acc_valid_o),
        .done_o      (done_o),
        .overflow_o  (overflow_o)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] pack4(input int l0, input int l1, input int l2, input int l3);
        return {l3, l2, l1, l0};
    endfunction

    function automatic logic [63:0] npack(input int l0, input int l1, input int l2, input int l3);
        return {16'(l3), 16'(l2), 16'(l1), 16'(l0)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic f, input logic l, input logic d,
                         input logic [63:0] n, input logic [15:0] w);
        valid = v; first = f; last = l; drain = d; north = n; west = w;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done_o !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check(tag, done_o, 1'b1);
    endtask

    logic [63:0]  exp_n;
    logic [15:0]  exp_w;
    logic [127:0] exp_acc;

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, '0, '0);
        repeat (3) tick();
        check("rst_valid_o", valid_o, 1'b0);
        check("rst_south_o", south_o, '0);
        check("rst_east_o", east_o, '0);
        check("rst_acc_o", acc_o, '0);
        check("rst_flags", {acc_valid_o, done_o, overflow_o}, 3'b000);
        rst = 1'b0;
        tick();

        // Three-element accumulation; drain requests in IDLE/ACCUM must be ignored.
        drive(1, 1, 0, 1, npack(1, -1, 3, 100), 16'd2);
        tick();
        check("idle_drain_no_strobe", acc_valid_o, 1'b0);
        drive(1, 0, 0, 1, npack(1, -1, 3, 100), 16'd2);
        tick();
        check("accum_drain_no_strobe", acc_valid_o, 1'b0);
        drive(1, 0, 1, 0, npack(1, -1, 3, 100), 16'd2);
        tick();
        drive(0, 0, 0, 0, '0, '0);
        tick();
        check("done_lat_p1", done_o, 1'b0);
        tick();
        check("done_lat_p2", done_o, 1'b0);
        tick();
        check("done_lat_p3", done_o, 1'b1);
        tick();
        check("done_sticky", {done_o, acc_valid_o}, 2'b10);
        drain = 1'b1;
        tick();
        drain = 1'b0;
        check("drain_strobe", acc_valid_o, 1'b1);
        check("drain_acc3", acc_o, pack4(6, -6, 18, 600));
        check("drain_done_clr", done_o, 1'b0);
        tick();
        check("strobe_one_cycle", acc_valid_o, 1'b0);
        check("acc_hold", acc_o, pack4(6, -6, 18, 600));

        // Back-to-back passthrough
        for (int i = 0; i < 8; i++) begin
            exp_n = npack(i + 1, i + 2, 3 * i, -i);
            exp_w = 16'(100 + i);
            drive(1, (i == 0), 0, 0, exp_n, exp_w);
            tick();
            check("pt_valid", valid_o, 1'b1);
            check("pt_south", south_o, exp_n);
            check("pt_east", east_o, exp_w);
        end
        drive(0, 0, 0, 0, 64'hDEAD_BEEF_0000_1111, 16'h5555);
        tick();
        check("pt_valid_low", valid_o, 1'b0);
        check("pt_south_hold", south_o, exp_n);
        check("pt_east_hold", east_o, exp_w);

        // Reset in the middle of an accumulation
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_outputs", {valid_o, acc_valid_o, done_o, overflow_o}, 4'b0000);
        check("midrst_acc_o", acc_o, '0);
        drive(1, 1, 1, 0, npack(4, 0, 0, 0), 16'd1);
        tick();
        drive(0, 0, 0, 0, '0, '0);
        wait_done("postrst_done");
        drain = 1'b1;
        tick();
        drain = 1'b0;
        check("postrst_strobe", acc_valid_o, 1'b1);
        check("postrst_acc", acc_o, pack4(4, 0, 0, 0));

        // Single first+last element, plus valid traffic while in DONE
        drive(1, 1, 1, 0, npack(7, 0, 0, 0), 16'hFFFB);
        tick();
        drive(0, 0, 0, 0, '0, '0);
        wait_done("single_done");
        drive(1, 1, 0, 0, npack(9, 9, 9, 9), 16'd9);
        tick();
        drive(0, 0, 0, 0, '0, '0);
        check("done_pt_east", east_o, 16'd9);
        check("done_pt_valid", valid_o, 1'b1);
        check("done_valid_no_strobe", {done_o, acc_valid_o}, 2'b10);
        tick();
        drain = 1'b1;
        tick();
        drain = 1'b0;
        check("single_strobe", acc_valid_o, 1'b1);
        check("single_acc", acc_o, pack4(-35, 0, 0, 0));

        // Three 32767*32767 products push lane0 past the 32-bit signed range
        drive(1, 1, 0, 0, npack(32767, 0, 0, 0), 16'd32767);
        tick();
        first = 1'b0;
        tick();
        last = 1'b1;
        tick();
        drive(0, 0, 0, 0, '0, '0);
        wait_done("sat_done");
`ifdef PE_SATURATE_EN
        exp_acc = pack4(2147483647, 0, 0, 0);
        check("sat_ovf_flag", overflow_o, 1'b1);
`else
        exp_acc = pack4(-1073938429, 0, 0, 0);
        check("wrap_ovf_flag", overflow_o, 1'b0);
`endif
        drain = 1'b1;
        tick();
        drain = 1'b0;
        check("big_acc", acc_o, exp_acc);
        check("ovf_cleared", overflow_o, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_pe_vec_cell
`default_nettype wire
